// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: Q4.12 sample type, limits and saturating gain.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 12;

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Left-shift by 0..3 using three guard bits, then clamp to the sample range.
  function automatic sample_t sat_shl(input sample_t x, input logic [1:0] sh);
    logic signed [DATA_W+2:0] p;
    logic signed [DATA_W+2:0] p_max;
    logic signed [DATA_W+2:0] p_min;
    p_max = {3'b000, SAMPLE_MAX};
    p_min = {3'b111, SAMPLE_MIN};
    p     = {{3{x[DATA_W-1]}}, x};
    p     = p <<< sh;
    if (p > p_max)      sat_shl = SAMPLE_MAX;
    else if (p < p_min) sat_shl = SAMPLE_MIN;
    else                sat_shl = p[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head entry is always on o_rdata.
module sync_fifo_fwft #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_rd,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   w_level;
  logic          w_do_rd;
  logic          w_do_wr;

  // Extra pointer bit makes the difference a true occupancy 0..DEPTH.
  assign w_level = r_wptr - r_rptr;
  assign o_full  = (w_level == (AW+1)'(DEPTH));
  assign o_empty = (w_level == '0);
  assign o_level = w_level;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // A write into a full FIFO is allowed when the head leaves the same cycle.
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  // Pointer update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage; cleared on reset so the output reads 0 until the first write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// FIR output stage: warm-up discard, decimation, saturating gain, FWFT buffer.
// DATA_W must match fir_pkg::DATA_W since the gain works on sample_t.
module fir_decim_out_buffer #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             y_in,
  input  logic                          en,
  input  logic [1:0]                    shift,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              overflow_cnt
);
  import fir_pkg::*;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [0:0] ST_RST    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PH_W = (DECIM  > 1) ? $clog2(DECIM)  : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [0:0]       r_state;
  logic [WC_W-1:0]  r_wcnt;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_ovf;

  logic             w_keep;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  sample_t          w_gain;

  // Warm-up discard, then count enabled samples modulo DECIM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RST;
      r_wcnt  <= '0;
      r_phase <= '0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (en) begin
            if (r_wcnt == WC_LAST) begin
              r_state <= ST_RUN;
              r_phase <= '0;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (en) r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign w_keep = (r_state == ST_RUN) && en && (r_phase == '0);
  assign w_gain = sat_shl(sample_t'(y_in), shift);
  assign w_pop  = m_valid && m_ready;

  // Saturating count of kept samples lost to a full, non-draining FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= '0;
    end else if (w_keep && w_full && !w_pop && (r_ovf != '1)) begin
      r_ovf <= r_ovf + 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_wr    (w_keep),
    .i_wdata (w_gain),
    .i_rd    (m_ready),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign m_valid      = !w_empty;
  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Directed + random bench for fir_decim_out_buffer against a queue-based reference.
module tb_fir_decim_out_buffer;
  localparam int WARMUP = 8;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 8;

  logic        clk;
  logic        rst;
  logic [15:0] y_in;
  logic        en;
  logic [1:0]  shift;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: queued outputs, drop count, enabled samples since reset.
  logic [15:0] q[$];
  int          ovf;
  int          n_en;

  fir_decim_out_buffer #(
    .DATA_W(16), .DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .en(en), .shift(shift),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_gain(input logic [15:0] y, input logic [1:0] sh);
    int v;
    v = int'($signed(y)) * (1 << sh);
    if (v > 32767)       v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(m_valid), 32'(q.size() != 0));
    chk("level", 32'(fifo_level), q.size());
    chk("ovf", 32'(overflow_cnt), ovf);
    if (q.size() != 0) chk("data", 32'(m_data), 32'(q[0]));
  endtask

  // Apply the edge to the reference using the inputs presented this cycle.
  task automatic model_edge();
    bit pop;
    bit keep;
    pop  = (q.size() != 0) && m_ready;
    keep = en && (n_en >= WARMUP) && (((n_en - WARMUP) % DECIM) == 0);
    if (en) n_en++;
    if (pop) void'(q.pop_front());
    if (keep) begin
      if (q.size() < DEPTH) q.push_back(ref_gain(y_in, shift));
      else if (ovf < 255) ovf++;
    end
  endtask

  task automatic step(input logic e, input logic [15:0] y, input logic [1:0] sh, input logic rdy);
    en = e; y_in = y; shift = sh; m_ready = rdy;
    if (rst) model_edge();
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic model_clear();
    q.delete(); ovf = 0; n_en = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    step(1'b1, 16'h1234, 2'd0, 1'b1);
    rst = 1'b1;
  endtask

  task automatic warmup(input logic rdy);
    for (int i = 0; i < WARMUP; i++) step(1'b1, 16'(16'h0F00 + i), 2'd0, rdy);
  endtask

  logic [15:0] sat_y  [5] = '{16'h2001, 16'h1FFF, 16'hE000, 16'hDFFF, 16'hFFFF};
  logic [1:0]  sat_sh [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [15:0] sat_exp[5] = '{16'h7FFF, 16'h7FFC, 16'h8000, 16'h8000, 16'hFFF8};

  initial begin
    rst = 1'b0; en = 1'b0; y_in = '0; shift = '0; m_ready = 1'b0;
    model_clear();
    #2;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Warm-up and decimation: y_in = k on enabled sample k.
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 16'(k), 2'd0, 1'b1);
      if (k == 7) chk("warm_no_valid", 32'(m_valid), 0);
      if (k == 8) begin
        chk("first_valid", 32'(m_valid), 1);
        chk("first_kept", 32'(m_data), 8);
      end
      if (k == 12) chk("second_kept", 32'(m_data), 12);
    end

    // Saturating gain corners, one kept sample per table entry.
    do_reset();
    warmup(1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, sat_y[i], sat_sh[i], 1'b1);
      chk("sat", 32'(m_data), 32'(sat_exp[i]));
      for (int j = 0; j < 3; j++) step(1'b1, 16'h0000, 2'd0, 1'b1);
    end

    // Backpressure: ten kept samples into an eight-deep FIFO.
    do_reset();
    warmup(1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 16'(100 + i), 2'd0, 1'b0);
    chk("bp_level", 32'(fifo_level), 8);
    chk("bp_ovf", 32'(overflow_cnt), 2);
    chk("bp_head", 32'(m_data), 100);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
    chk("bp_drained", 32'(m_valid), 0);

    // Full FIFO with a pop on the same cycle a sample is kept.
    do_reset();
    warmup(1'b0);
    for (int i = 0; i < 32; i++) step(1'b1, 16'(200 + i), 2'd1, 1'b0);
    step(1'b1, 16'h0555, 2'd0, 1'b1);
    chk("fp_level", 32'(fifo_level), 8);
    chk("fp_ovf", 32'(overflow_cnt), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 2'd0, 1'b1);

    // Enable gaps: 1,0,0 pattern in RUN.
    for (int i = 0; i < 48; i++) step((i % 3) == 0, 16'(300 + i), 2'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 6);

    // Mid-operation reset with 5 entries held and 3 drops counted.
    do_reset();
    warmup(1'b0);
    for (int i = 0; i < 44; i++) step(1'b1, 16'(400 + i), 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
    m_ready = 1'b0;
    chk("mid_level", 32'(fifo_level), 5);
    chk("mid_ovf", 32'(overflow_cnt), 3);
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(m_valid), 0);
    chk("async_level", 32'(fifo_level), 0);
    chk("async_ovf", 32'(overflow_cnt), 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < WARMUP; i++) step(1'b1, 16'(500 + i), 2'd0, 1'b1);
    chk("rewarm_no_valid", 32'(m_valid), 0);
    step(1'b1, 16'h0777, 2'd0, 1'b1);
    chk("rewarm_kept", 32'(m_data), 32'h0777);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(600 + i), 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
